// File: rtl/riscv_trace_pkg.sv
// ============================================================================
// Module  : riscv_trace_pkg
// Brief   : Shared types and constants for the retire-trace capture buffer:
//           capture state encoding, trigger-mode codes, entry layout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_trace_pkg;

  // Default geometry of one trace entry.
  localparam int c_XLEN  = 64;
  localparam int c_ILEN  = 32;
  localparam int c_DEPTH = 16;
  localparam int c_TS_W  = 16;

  // Capture state machine encoding (visible on the state output).
  typedef enum logic [1:0] {
    c_ST_IDLE  = 2'd0,
    c_ST_ARMED = 2'd1,
    c_ST_POST  = 2'd2,
    c_ST_DONE  = 2'd3
  } trace_state_e;

  // Trigger qualification modes.
  localparam logic [1:0] c_MODE_IMM    = 2'd0;
  localparam logic [1:0] c_MODE_PC     = 2'd1;
  localparam logic [1:0] c_MODE_INSTR  = 2'd2;
  localparam logic [1:0] c_MODE_MANUAL = 2'd3;

  // Layout of one stored entry, most significant field first.
  typedef struct packed {
    logic [c_TS_W-1:0] ts;
    logic [c_XLEN-1:0] pc;
    logic [c_ILEN-1:0] instr;
    logic [c_XLEN-1:0] result;
  } trace_entry_t;

  // Packed width of one entry for arbitrary field widths.
  function automatic int entry_width(input int ts_w, input int xlen, input int ilen);
    return ts_w + xlen + ilen + xlen;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
// Module  : trace_ram
// Brief   : DEPTH x WIDTH storage, one write port and one synchronous read
//           port. No reset on contents. A read of the entry being written in
//           the same cycle returns the previous contents.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port: store one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered read, old-data on read/write collision.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/riscv_trace_buffer.sv
// ============================================================================
// Module  : riscv_trace_buffer
// Brief   : On-chip retire-trace capture. Records {ts, pc, instr, result} per
//           valid sample into a circular buffer, with trigger qualification,
//           programmable post-trigger depth and oldest-relative readout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter  int XLEN  = c_XLEN,
  parameter  int ILEN  = c_ILEN,
  parameter  int DEPTH = c_DEPTH,
  parameter  int TS_W  = c_TS_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_trc_valid,
  input  logic [XLEN-1:0] i_trc_pc,
  input  logic [ILEN-1:0] i_trc_instr,
  input  logic [XLEN-1:0] i_trc_result,
  input  logic            i_arm,
  input  logic [1:0]      i_trig_mode,
  input  logic [XLEN-1:0] i_trig_value,
  input  logic            i_trig_force,
  input  logic [AW:0]     i_post_count,
  output logic [1:0]      o_state,
  output logic [AW:0]     o_entry_count,
  output logic [AW-1:0]   o_trig_index,
  input  logic            i_rd_en,
  input  logic [AW-1:0]   i_rd_addr,
  output logic            o_rd_valid,
  output logic [TS_W-1:0] o_rd_ts,
  output logic [XLEN-1:0] o_rd_pc,
  output logic [ILEN-1:0] o_rd_instr,
  output logic [XLEN-1:0] o_rd_result
);

  localparam int            CW      = AW + 1;
  localparam int            EW      = entry_width(TS_W, XLEN, ILEN);
  localparam logic [CW-1:0] c_FULL  = CW'(DEPTH);

  trace_state_e  r_state;
  trace_state_e  w_state_nxt;
  logic [TS_W-1:0] r_ts;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_post_rem;
  logic [CW-1:0]   r_post_cfg;
  logic [AW-1:0]   r_trig_index;
  logic            r_rd_valid;

  logic [CW-1:0]   w_post_clamp;
  logic [CW-1:0]   w_post_used;
  logic [CW-1:0]   w_count_inc;
  logic [AW-1:0]   w_trig_idx;
  logic            w_capture;
  logic            w_wr_en;
  logic            w_match;
  logic            w_trig;
  logic            w_enter_done;
  logic [AW-1:0]   w_rd_phys;
  logic            w_rd_ok;
  logic [EW-1:0]   w_wr_data;
  logic [EW-1:0]   w_rd_data;

  // Post-trigger depth larger than the buffer keeps exactly one full buffer.
  assign w_post_clamp = (i_post_count > c_FULL) ? c_FULL : i_post_count;

  // Samples are stored only while capturing; an arm pulse discards the
  // coincident sample because it also restarts the buffer.
  assign w_capture = (r_state == c_ST_ARMED) || (r_state == c_ST_POST);
  assign w_wr_en   = i_trc_valid & w_capture & ~i_arm;
  assign w_count_inc = (r_count == c_FULL) ? r_count : r_count + 1'b1;

  // Trigger comparator for the selected mode; manual mode fires only on force.
  always_comb begin
    w_match = 1'b0;
    case (i_trig_mode)
      c_MODE_IMM:    w_match = 1'b1;
      c_MODE_PC:     w_match = (i_trc_pc == i_trig_value);
      c_MODE_INSTR:  w_match = (i_trc_instr == i_trig_value[ILEN-1:0]);
      c_MODE_MANUAL: w_match = 1'b0;
      default:       w_match = 1'b0;
    endcase
  end

  assign w_trig = (r_state == c_ST_ARMED) & i_trc_valid & ~i_arm & (i_trig_force | w_match);

  // Next-state logic: arm wins from any state, then trigger / post countdown.
  always_comb begin
    w_state_nxt = r_state;
    if (i_arm) begin
      w_state_nxt = c_ST_ARMED;
    end else begin
      case (r_state)
        c_ST_ARMED: begin
          if (w_trig) begin
            w_state_nxt = (w_post_clamp == '0) ? c_ST_DONE : c_ST_POST;
          end
        end
        c_ST_POST: begin
          if (w_wr_en && (r_post_rem == CW'(1))) begin
            w_state_nxt = c_ST_DONE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Trigger position once capture completes: the trigger sits post_count
  // entries behind the newest one, or has been overwritten when that
  // reaches past the oldest entry.
  assign w_enter_done = (w_state_nxt == c_ST_DONE) && (r_state != c_ST_DONE);
  assign w_post_used  = (r_state == c_ST_ARMED) ? w_post_clamp : r_post_cfg;
  assign w_trig_idx   = (w_count_inc > w_post_used) ?
                        AW'(w_count_inc - 1'b1 - w_post_used) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timestamp, write pointer, fill count, post-trigger countdown, trigger index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts         <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_post_rem   <= '0;
      r_post_cfg   <= '0;
      r_trig_index <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (i_arm) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= w_count_inc;
      end
      if (w_trig) begin
        r_post_rem <= w_post_clamp;
        r_post_cfg <= w_post_clamp;
      end else if ((r_state == c_ST_POST) && w_wr_en) begin
        r_post_rem <= r_post_rem - 1'b1;
      end
      if (w_enter_done) begin
        r_trig_index <= w_trig_idx;
      end
    end
  end

  // Oldest-relative address translation and range qualification.
  assign w_rd_phys = r_wr_ptr - r_count[AW-1:0] + i_rd_addr;
  assign w_rd_ok   = i_rd_en & ({1'b0, i_rd_addr} < r_count);

  // Read-valid flag aligned with the one-cycle RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
    end
  end

  assign w_wr_data = {r_ts, i_trc_pc, i_trc_instr, i_trc_result};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (i_rd_en),
    .i_rd_addr (w_rd_phys),
    .o_rd_data (w_rd_data)
  );

  // Invalid reads return zeros rather than stale RAM contents.
  assign {o_rd_ts, o_rd_pc, o_rd_instr, o_rd_result} = r_rd_valid ? w_rd_data : '0;

  assign o_rd_valid    = r_rd_valid;
  assign o_state       = r_state;
  assign o_entry_count = r_count;
  assign o_trig_index  = r_trig_index;

endmodule

`default_nettype wire

// File: tb/tb_riscv_trace_buffer.sv
// ============================================================================
// Module  : tb_riscv_trace_buffer
// Brief   : Directed self-checking bench for riscv_trace_buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trc_valid = 1'b0;
  logic [63:0] trc_pc = '0;
  logic [31:0] trc_instr = '0;
  logic [63:0] trc_result = '0;
  logic        arm = 1'b0;
  logic [1:0]  trig_mode = '0;
  logic [63:0] trig_value = '0;
  logic        trig_force = 1'b0;
  logic [4:0]  post_count = '0;
  logic [1:0]  state;
  logic [4:0]  entry_count;
  logic [3:0]  trig_index;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_valid;
  logic [15:0] rd_ts;
  logic [63:0] rd_pc;
  logic [31:0] rd_instr;
  logic [63:0] rd_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_trace_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .i_trc_valid   (trc_valid),
    .i_trc_pc      (trc_pc),
    .i_trc_instr   (trc_instr),
    .i_trc_result  (trc_result),
    .i_arm         (arm),
    .i_trig_mode   (trig_mode),
    .i_trig_value  (trig_value),
    .i_trig_force  (trig_force),
    .i_post_count  (post_count),
    .o_state       (state),
    .o_entry_count (entry_count),
    .o_trig_index  (trig_index),
    .i_rd_en       (rd_en),
    .i_rd_addr     (rd_addr),
    .o_rd_valid    (rd_valid),
    .o_rd_ts       (rd_ts),
    .o_rd_pc       (rd_pc),
    .o_rd_instr    (rd_instr),
    .o_rd_result   (rd_result)
  );

  // Advance one cycle; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse(input logic [1:0] mode, input logic [63:0] val, input logic [4:0] post);
    trig_mode  = mode;
    trig_value = val;
    post_count = post;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // One retired-instruction sample; instr/result derived from pc.
  task automatic sample(input logic [63:0] pc, input logic frc);
    trc_valid  = 1'b1;
    trc_pc     = pc;
    trc_instr  = pc[31:0] ^ 32'h0000_0013;
    trc_result = ~pc;
    trig_force = frc;
    step();
    trc_valid  = 1'b0;
    trig_force = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if (entry_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", entry_count); end
    n_checks++; if (trig_index !== 4'd0) begin n_fail++; $display("FAIL reset_trig_index: got %0d expected 0", trig_index); end
    n_checks++; if (rd_valid !== 1'b0 || rd_pc !== 64'd0 || rd_ts !== 16'd0) begin
      n_fail++; $display("FAIL reset_rd: got valid=%0b pc=%h ts=%h expected 0/0/0", rd_valid, rd_pc, rd_ts); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_immediate();
    arm_pulse(2'd0, 64'd0, 5'd3);
    n_checks++; if (state !== 2'd1 || entry_count !== 5'd0) begin
      n_fail++; $display("FAIL imm_armed: got state=%0d count=%0d expected 1/0", state, entry_count); end
    sample(64'h0, 1'b0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL imm_post: got %0d expected 2", state); end
    sample(64'h4, 1'b0);
    sample(64'h8, 1'b0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL imm_still_post: got %0d expected 2", state); end
    sample(64'hC, 1'b0);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL imm_done: got %0d expected 3", state); end
    sample(64'h10, 1'b0);
    n_checks++; if (entry_count !== 5'd4) begin n_fail++; $display("FAIL imm_count: got %0d expected 4", entry_count); end
    n_checks++; if (trig_index !== 4'd0) begin n_fail++; $display("FAIL imm_trig_index: got %0d expected 0", trig_index); end
  endtask

  task automatic test_read_window();
    logic [15:0] prev_ts;
    prev_ts = '0;
    rd(4'd5);
    n_checks++; if (rd_valid !== 1'b0 || rd_pc !== 64'd0 || rd_instr !== 32'd0 || rd_result !== 64'd0) begin
      n_fail++; $display("FAIL rd_out_of_range: got valid=%0b pc=%h expected 0/0", rd_valid, rd_pc); end
    rd(4'd4);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_at_count: got %0b expected 0", rd_valid); end
    for (int a = 0; a < 4; a++) begin
      rd(a[3:0]);
      n_checks++; if (rd_valid !== 1'b1 || rd_pc !== 64'(4 * a)) begin
        n_fail++; $display("FAIL rd_entry%0d: got valid=%0b pc=%h expected 1/%h", a, rd_valid, rd_pc, 4 * a); end
      n_checks++; if (rd_instr !== (32'(4 * a) ^ 32'h13) || rd_result !== ~64'(4 * a)) begin
        n_fail++; $display("FAIL rd_payload%0d: got instr=%h result=%h", a, rd_instr, rd_result); end
      if (a > 0) begin
        n_checks++; if (rd_ts !== prev_ts + 16'd1) begin
          n_fail++; $display("FAIL rd_ts%0d: got %h expected %h", a, rd_ts, prev_ts + 16'd1); end
      end
      prev_ts = rd_ts;
    end
  endtask

  task automatic test_pc_match();
    arm_pulse(2'd1, 64'h40, 5'd2);
    for (int i = 0; i < 30; i++) begin
      sample(64'(4 * i), 1'b0);
      if (i == 15) begin
        n_checks++; if (state !== 2'd1 || entry_count !== 5'd16) begin
          n_fail++; $display("FAIL pc_pre_trig: got state=%0d count=%0d expected 1/16", state, entry_count); end
      end
      if (i == 16) begin
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pc_trig: got %0d expected 2", state); end
      end
      if (i == 17) begin
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL pc_post17: got %0d expected 2", state); end
      end
      if (i == 18) begin
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL pc_done: got %0d expected 3", state); end
      end
    end
    n_checks++; if (entry_count !== 5'd16) begin n_fail++; $display("FAIL pc_count: got %0d expected 16", entry_count); end
    n_checks++; if (trig_index !== 4'd13) begin n_fail++; $display("FAIL pc_trig_index: got %0d expected 13", trig_index); end
    rd(4'd0);
    n_checks++; if (rd_valid !== 1'b1 || rd_pc !== 64'hC) begin
      n_fail++; $display("FAIL pc_oldest: got valid=%0b pc=%h expected 1/c", rd_valid, rd_pc); end
    rd(4'd13);
    n_checks++; if (rd_pc !== 64'h40) begin n_fail++; $display("FAIL pc_trig_entry: got %h expected 40", rd_pc); end
    rd(4'd15);
    n_checks++; if (rd_pc !== 64'h48) begin n_fail++; $display("FAIL pc_newest: got %h expected 48", rd_pc); end
  endtask

  task automatic test_manual_force();
    arm_pulse(2'd3, 64'h0, 5'd0);
    for (int i = 0; i < 40; i++) sample(64'(4 * i), 1'b0);
    n_checks++; if (state !== 2'd1 || entry_count !== 5'd16) begin
      n_fail++; $display("FAIL man_armed: got state=%0d count=%0d expected 1/16", state, entry_count); end
    sample(64'hF00, 1'b1);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL man_done: got %0d expected 3", state); end
    n_checks++; if (trig_index !== 4'd15) begin n_fail++; $display("FAIL man_trig_index: got %0d expected 15", trig_index); end
    rd(4'd15);
    n_checks++; if (rd_pc !== 64'hF00) begin n_fail++; $display("FAIL man_newest: got %h expected f00", rd_pc); end
    rd(4'd0);
    n_checks++; if (rd_pc !== 64'h64) begin n_fail++; $display("FAIL man_oldest: got %h expected 64", rd_pc); end
  endtask

  task automatic test_arm_priority();
    trig_mode  = 2'd0;
    post_count = 5'd5;
    trc_valid  = 1'b1;
    trc_pc     = 64'h99;
    arm        = 1'b1;
    step();
    arm        = 1'b0;
    trc_valid  = 1'b0;
    n_checks++; if (state !== 2'd1 || entry_count !== 5'd0) begin
      n_fail++; $display("FAIL arm_drop: got state=%0d count=%0d expected 1/0", state, entry_count); end
    sample(64'h100, 1'b0);
    n_checks++; if (state !== 2'd2 || entry_count !== 5'd1) begin
      n_fail++; $display("FAIL arm_post: got state=%0d count=%0d expected 2/1", state, entry_count); end
    arm = 1'b1;
    step();
    arm = 1'b0;
    n_checks++; if (state !== 2'd1 || entry_count !== 5'd0) begin
      n_fail++; $display("FAIL arm_rearm: got state=%0d count=%0d expected 1/0", state, entry_count); end
    rd(4'd0);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL arm_rd_empty: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_post_clamp();
    arm_pulse(2'd0, 64'h0, 5'd20);
    for (int i = 0; i < 16; i++) sample(64'(8 * i), 1'b0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL clamp_post: got %0d expected 2", state); end
    sample(64'h1000, 1'b0);
    n_checks++; if (state !== 2'd3 || entry_count !== 5'd16) begin
      n_fail++; $display("FAIL clamp_done: got state=%0d count=%0d expected 3/16", state, entry_count); end
    n_checks++; if (trig_index !== 4'd0) begin n_fail++; $display("FAIL clamp_trig_index: got %0d expected 0", trig_index); end
  endtask

  task automatic test_reset_mid_post();
    // Leave a nonzero trigger index behind so the reset is observable.
    arm_pulse(2'd3, 64'h0, 5'd0);
    sample(64'h10, 1'b0);
    sample(64'h14, 1'b0);
    sample(64'h18, 1'b1);
    n_checks++; if (trig_index !== 4'd2) begin n_fail++; $display("FAIL rst_pre_idx: got %0d expected 2", trig_index); end
    arm_pulse(2'd0, 64'h0, 5'd5);
    sample(64'h20, 1'b0);
    sample(64'h24, 1'b0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_post: got %0d expected 2", state); end
    rd_en = 1'b1; rd_addr = 4'd0; trc_valid = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (state !== 2'd0 || entry_count !== 5'd0 || trig_index !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid: got state=%0d count=%0d idx=%0d expected 0/0/0", state, entry_count, trig_index); end
    n_checks++; if (rd_valid !== 1'b0 || rd_pc !== 64'd0) begin
      n_fail++; $display("FAIL rst_rd: got valid=%0b pc=%h expected 0/0", rd_valid, rd_pc); end
    rd_en = 1'b0;
    step(); step(); step();
    trc_valid = 1'b0;
    n_checks++; if (state !== 2'd0 || entry_count !== 5'd0) begin
      n_fail++; $display("FAIL rst_ignore: got state=%0d count=%0d expected 0/0", state, entry_count); end
    arm_pulse(2'd0, 64'h0, 5'd0);
    sample(64'h30, 1'b0);
    n_checks++; if (state !== 2'd3 || entry_count !== 5'd1 || trig_index !== 4'd0) begin
      n_fail++; $display("FAIL rst_rearm: got state=%0d count=%0d idx=%0d expected 3/1/0", state, entry_count, trig_index); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_read_window();
    test_pc_match();
    test_manual_force();
    test_arm_priority();
    test_post_clamp();
    test_reset_mid_post();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
